// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RISC-V control unit: FSM states, opcodes,
// datapath mux selects and ALU operation codes.
package riscv_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_EXECI    = 4'd7,
      S_ALUWB    = 4'd8,
      S_BRANCH   = 4'd9,
      S_JAL      = 4'd10
   } state_e;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   localparam logic [1:0] RES_ALUOUT = 2'b00;
   localparam logic [1:0] RES_DATA   = 2'b01;
   localparam logic [1:0] RES_ALU    = 2'b10;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;

   localparam logic [1:0] SRCB_RS2   = 2'b00;
   localparam logic [1:0] SRCB_IMM   = 2'b01;
   localparam logic [1:0] SRCB_FOUR  = 2'b10;

   localparam logic [1:0] IMM_I = 2'b00;
   localparam logic [1:0] IMM_S = 2'b01;
   localparam logic [1:0] IMM_B = 2'b10;
   localparam logic [1:0] IMM_J = 2'b11;

   // alu_op: what the main FSM asks of the ALU decoder
   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SLL = 3'b001;
   localparam logic [2:0] ALU_SUB = 3'b010;
   localparam logic [2:0] ALU_XOR = 3'b100;
   localparam logic [2:0] ALU_SRL = 3'b101;
   localparam logic [2:0] ALU_OR  = 3'b110;
   localparam logic [2:0] ALU_AND = 3'b111;

   function automatic logic [1:0] imm_src_of(input logic [6:0] op);
      case (op)
         OP_STORE:  return IMM_S;
         OP_BRANCH: return IMM_B;
         OP_JAL:    return IMM_J;
         default:   return IMM_I;
      endcase
   endfunction

endpackage

// File: rtl/alu_decoder.sv
// ALU decoder: maps the FSM's alu_op request plus instruction fields to an ALU code.
module alu_decoder
   import riscv_ctrl_pkg::*;
(
   input  logic [1:0] alu_op_i,
   input  logic [2:0] funct3_i,
   input  logic       op5_i,
   input  logic       funct7b5_i,
   output logic [2:0] alu_control_o
);

   always_comb begin
      alu_control_o = ALU_ADD;
      case (alu_op_i)
         ALUOP_ADD: alu_control_o = ALU_ADD;
         ALUOP_SUB: alu_control_o = ALU_SUB;
         ALUOP_FUNCT: begin
            case (funct3_i)
               // I-type has op[5]=0, so addi never becomes sub even with bit 30 set
               3'b000:  alu_control_o = (op5_i && funct7b5_i) ? ALU_SUB : ALU_ADD;
               3'b001:  alu_control_o = ALU_SLL;
               3'b100:  alu_control_o = ALU_XOR;
               3'b101:  alu_control_o = ALU_SRL;
               3'b110:  alu_control_o = ALU_OR;
               3'b111:  alu_control_o = ALU_AND;
               default: alu_control_o = ALU_ADD;
            endcase
         end
         default: alu_control_o = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM of the multi-cycle RISC-V core: sequences fetch/decode/execute/
// memory/writeback and drives every datapath enable and mux select.
module multicycle_controller
   import riscv_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       zero,
   input  logic       alu_neg,
   input  logic       mem_ready,
   output logic       pc_write,
   output logic       adr_src,
   output logic       mem_write,
   output logic       ir_write,
   output logic       reg_write,
   output logic [1:0] result_src,
   output logic [1:0] alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] imm_src,
   output logic [2:0] alu_control,
   output logic       instr_done,
   output logic       illegal,
   output logic [3:0] state
);

   state_e     state_q, state_d;
   logic [1:0] alu_op;
   logic       taken;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_FETCH;
      else     state_q <= state_d;
   end

   // Signed-less-than uses the raw sign bit; overflow is intentionally not corrected
   always_comb begin
      case (funct3)
         3'b000:  taken = zero;
         3'b001:  taken = ~zero;
         3'b100:  taken = alu_neg;
         default: taken = 1'b0;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      pc_write   = 1'b0;
      adr_src    = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      reg_write  = 1'b0;
      result_src = RES_ALUOUT;
      alu_src_a  = SRCA_PC;
      alu_src_b  = SRCB_RS2;
      alu_op     = ALUOP_ADD;
      instr_done = 1'b0;
      illegal    = 1'b0;

      case (state_q)
         S_FETCH: begin
            alu_src_b  = SRCB_FOUR;
            result_src = RES_ALU;
            ir_write   = mem_ready;
            pc_write   = mem_ready;
            if (mem_ready) state_d = S_DECODE;
         end
         S_DECODE: begin
            alu_src_a = SRCA_OLDPC;
            alu_src_b = SRCB_IMM;
            case (op)
               OP_LOAD, OP_STORE: state_d = S_MEMADR;
               OP_RTYPE:          state_d = S_EXECR;
               OP_ITYPE:          state_d = S_EXECI;
               OP_BRANCH:         state_d = S_BRANCH;
               OP_JAL:            state_d = S_JAL;
               default: begin
                  state_d    = S_FETCH;
                  illegal    = 1'b1;
                  instr_done = 1'b1;
               end
            endcase
         end
         S_MEMADR: begin
            alu_src_a = SRCA_RS1;
            alu_src_b = SRCB_IMM;
            state_d   = op[5] ? S_MEMWRITE : S_MEMREAD;
         end
         S_MEMREAD: begin
            adr_src = 1'b1;
            if (mem_ready) state_d = S_MEMWB;
         end
         S_MEMWRITE: begin
            adr_src    = 1'b1;
            mem_write  = 1'b1;
            instr_done = mem_ready;
            if (mem_ready) state_d = S_FETCH;
         end
         S_MEMWB: begin
            result_src = RES_DATA;
            reg_write  = 1'b1;
            instr_done = 1'b1;
            state_d    = S_FETCH;
         end
         S_EXECR: begin
            alu_src_a = SRCA_RS1;
            alu_op    = ALUOP_FUNCT;
            state_d   = S_ALUWB;
         end
         S_EXECI: begin
            alu_src_a = SRCA_RS1;
            alu_src_b = SRCB_IMM;
            alu_op    = ALUOP_FUNCT;
            state_d   = S_ALUWB;
         end
         S_ALUWB: begin
            reg_write  = 1'b1;
            instr_done = 1'b1;
            state_d    = S_FETCH;
         end
         S_BRANCH: begin
            alu_src_a  = SRCA_RS1;
            alu_op     = ALUOP_SUB;
            pc_write   = taken;
            instr_done = 1'b1;
            state_d    = S_FETCH;
         end
         S_JAL: begin
            alu_src_a = SRCA_OLDPC;
            alu_src_b = SRCB_FOUR;
            pc_write  = 1'b1;
            state_d   = S_ALUWB;
         end
         default: state_d = S_FETCH;
      endcase
   end

   alu_decoder u_alu_decoder (
      .alu_op_i      (alu_op),
      .funct3_i      (funct3),
      .op5_i         (op[5]),
      .funct7b5_i    (funct7b5),
      .alu_control_o (alu_control)
   );

   assign imm_src = imm_src_of(op);
   assign state   = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: directed scenarios plus a randomized
// instruction stream checked against a path-based reference model.
module tb_multicycle_controller;

   logic       clk = 1'b0;
   logic       rst;
   logic [6:0] op;
   logic [2:0] funct3;
   logic       funct7b5;
   logic       zero;
   logic       alu_neg;
   logic       mem_ready;
   logic       pc_write, adr_src, mem_write, ir_write, reg_write;
   logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
   logic [2:0] alu_control;
   logic       instr_done, illegal;
   logic [3:0] state;

   int unsigned vectors = 0;
   int unsigned errors  = 0;

   typedef struct {
      int   st;
      logic mr;
   } cyc_t;

   multicycle_controller dut (
      .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5),
      .zero(zero), .alu_neg(alu_neg), .mem_ready(mem_ready),
      .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write),
      .ir_write(ir_write), .reg_write(reg_write), .result_src(result_src),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .imm_src(imm_src),
      .alu_control(alu_control), .instr_done(instr_done), .illegal(illegal),
      .state(state)
   );

   always #5 clk = ~clk;

   task automatic set_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7);
      op = o; funct3 = f3; funct7b5 = f7;
   endtask

   task automatic test_reset();
      mem_ready = 1'b0;
      #1;
      vectors++;
      if (state !== 4'd0 || ir_write !== 1'b0 || pc_write !== 1'b0 || result_src !== 2'b10) begin
         errors++;
         $display("FAIL reset_idle: state=%0d ir=%b pc=%b rs=%b, want 0 0 0 10", state, ir_write, pc_write, result_src);
      end
      // walk a load into MEMREAD and hold it there
      set_instr(7'b0000011, 3'b010, 1'b0);
      mem_ready = 1'b1;
      repeat (3) @(negedge clk);
      mem_ready = 1'b0;
      #1;
      vectors++;
      if (state !== 4'd3) begin
         errors++;
         $display("FAIL reset_pre_memread: state=%0d want 3", state);
      end
      #1 rst = 1'b1;
      #1;
      vectors++;
      if (state !== 4'd0) begin
         errors++;
         $display("FAIL reset_async: state=%0d want 0", state);
      end
      @(negedge clk);
      rst = 1'b0;
      mem_ready = 1'b1;
      #1;
      vectors++;
      if (state !== 4'd0 || ir_write !== 1'b1 || pc_write !== 1'b1) begin
         errors++;
         $display("FAIL reset_release: state=%0d ir=%b pc=%b, want 0 1 1", state, ir_write, pc_write);
      end
      mem_ready = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_lw();
      int exp_st[5] = '{0, 1, 2, 3, 4};
      int done_cnt = 0;
      set_instr(7'b0000011, 3'b010, 1'b0);
      mem_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1;
         vectors++;
         if (state !== 4'(exp_st[i])) begin
            errors++;
            $display("FAIL lw_state[%0d]: got %0d want %0d", i, state, exp_st[i]);
         end
         if (instr_done === 1'b1) done_cnt++;
         if (i == 4) begin
            vectors++;
            if (reg_write !== 1'b1 || result_src !== 2'b01 || instr_done !== 1'b1) begin
               errors++;
               $display("FAIL lw_memwb: rw=%b rs=%b done=%b want 1 01 1", reg_write, result_src, instr_done);
            end
         end
         @(negedge clk);
      end
      #1;
      vectors++;
      if (state !== 4'd0 || done_cnt != 1) begin
         errors++;
         $display("FAIL lw_end: state=%0d done_pulses=%0d want 0 1", state, done_cnt);
      end
      mem_ready = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_sw_stall();
      int   exp_st[7] = '{0, 1, 2, 5, 5, 5, 5};
      logic mr[7]     = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      int   mw_cnt = 0, done_cnt = 0;
      set_instr(7'b0100011, 3'b010, 1'b0);
      for (int i = 0; i < 7; i++) begin
         mem_ready = mr[i];
         #1;
         vectors++;
         if (state !== 4'(exp_st[i]) || (exp_st[i] == 5 && adr_src !== 1'b1)) begin
            errors++;
            $display("FAIL sw_cycle[%0d]: state=%0d adr=%b want %0d", i, state, adr_src, exp_st[i]);
         end
         if (mem_write === 1'b1) mw_cnt++;
         if (instr_done === 1'b1) done_cnt++;
         @(negedge clk);
      end
      mem_ready = 1'b0;
      #1;
      vectors++;
      if (state !== 4'd0 || mw_cnt != 4 || done_cnt != 1) begin
         errors++;
         $display("FAIL sw_summary: state=%0d mem_write_cycles=%0d done=%0d want 0 4 1", state, mw_cnt, done_cnt);
      end
      @(negedge clk);
   endtask

   task automatic test_alu_decode();
      logic [6:0] ops[2]  = '{7'b0110011, 7'b0010011};
      logic [2:0] want[2] = '{3'b010, 3'b000};
      logic [1:0] srcb[2] = '{2'b00, 2'b01};
      for (int t = 0; t < 2; t++) begin
         set_instr(ops[t], 3'b000, 1'b1);
         mem_ready = 1'b1;
         for (int i = 0; i < 4; i++) begin
            #1;
            if (i == 2) begin
               vectors++;
               if (state !== 4'(6 + t) || alu_control !== want[t] || alu_src_a !== 2'b10 || alu_src_b !== srcb[t]) begin
                  errors++;
                  $display("FAIL alu_decode[%0d]: state=%0d ctl=%b a=%b b=%b want %0d %b 10 %b",
                           t, state, alu_control, alu_src_a, alu_src_b, 6 + t, want[t], srcb[t]);
               end
            end
            @(negedge clk);
         end
         mem_ready = 1'b0;
         #1;
         vectors++;
         if (state !== 4'd0) begin
            errors++;
            $display("FAIL alu_decode_end[%0d]: state=%0d want 0", t, state);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_branch();
      logic [2:0] f3[3] = '{3'b000, 3'b001, 3'b100};
      logic       z[3]  = '{1'b1, 1'b1, 1'b0};
      logic       n[3]  = '{1'b0, 1'b0, 1'b1};
      logic       pw[3] = '{1'b1, 1'b0, 1'b1};
      for (int t = 0; t < 3; t++) begin
         set_instr(7'b1100011, f3[t], 1'b0);
         zero = z[t]; alu_neg = n[t];
         mem_ready = 1'b1;
         for (int i = 0; i < 3; i++) begin
            #1;
            if (i == 2) begin
               vectors++;
               if (state !== 4'd9 || pc_write !== pw[t] || alu_control !== 3'b010 || instr_done !== 1'b1) begin
                  errors++;
                  $display("FAIL branch[%0d]: state=%0d pc=%b ctl=%b done=%b want 9 %b 010 1",
                           t, state, pc_write, alu_control, instr_done, pw[t]);
               end
            end
            @(negedge clk);
         end
         mem_ready = 1'b0;
         @(negedge clk);
      end
   endtask

   task automatic test_illegal();
      logic any_wr = 1'b0;
      set_instr(7'b0110111, 3'b000, 1'b0);
      mem_ready = 1'b1;
      for (int i = 0; i < 2; i++) begin
         #1;
         any_wr = any_wr | reg_write | mem_write;
         if (i == 1) begin
            vectors++;
            if (state !== 4'd1 || illegal !== 1'b1 || instr_done !== 1'b1) begin
               errors++;
               $display("FAIL illegal_decode: state=%0d ill=%b done=%b want 1 1 1", state, illegal, instr_done);
            end
         end
         @(negedge clk);
      end
      mem_ready = 1'b0;
      #1;
      any_wr = any_wr | reg_write | mem_write;
      vectors++;
      if (state !== 4'd0 || illegal !== 1'b0 || any_wr !== 1'b0) begin
         errors++;
         $display("FAIL illegal_after: state=%0d ill=%b writes=%b want 0 0 0", state, illegal, any_wr);
      end
      @(negedge clk);
   endtask

   function automatic logic [2:0] model_alu(input int st, input bit rtype, input logic [2:0] f3, input logic f7);
      if (st == 9) return 3'b010;
      if (st != 6 && st != 7) return 3'b000;
      case (f3)
         3'd0:    return (rtype && f7) ? 3'b010 : 3'b000;
         3'd1:    return 3'b001;
         3'd4:    return 3'b100;
         3'd5:    return 3'b101;
         3'd6:    return 3'b110;
         3'd7:    return 3'b111;
         default: return 3'b000;
      endcase
   endfunction

   task automatic test_random();
      logic [6:0] good_ops[6] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111};
      logic [6:0] bad_ops[5]  = '{7'b0110111, 7'b0010111, 7'b1100111, 7'b0000000, 7'b1110011};
      for (int n = 0; n < 80; n++) begin
         int         cls;
         int         path[$];
         cyc_t       cq[$];
         logic [6:0] o;
         logic [2:0] f3;
         logic       f7, z, ng, tk, mr;
         logic [1:0] exp_imm, rs, sa, sb;
         logic [21:0] expv, obs;
         int         st;
         cls = $urandom_range(0, 6);
         o   = (cls == 6) ? bad_ops[$urandom_range(0, 4)] : good_ops[cls];
         f3  = 3'($urandom); f7 = 1'($urandom); z = 1'($urandom); ng = 1'($urandom);
         tk  = (f3 == 3'd0 && z) || (f3 == 3'd1 && !z) || (f3 == 3'd4 && ng);
         case (cls)
            0: path = '{0, 1, 2, 3, 4};
            1: path = '{0, 1, 2, 5};
            2: path = '{0, 1, 6, 8};
            3: path = '{0, 1, 7, 8};
            4: path = '{0, 1, 9};
            5: path = '{0, 1, 10, 8};
            default: path = '{0, 1};
         endcase
         foreach (path[p]) begin
            if (path[p] == 0 || path[p] == 3 || path[p] == 5) begin
               repeat ($urandom_range(0, 2)) cq.push_back('{path[p], 1'b0});
               cq.push_back('{path[p], 1'b1});
            end else
               cq.push_back('{path[p], 1'($urandom)});
         end
         exp_imm = (o == 7'b0100011) ? 2'b01 : (o == 7'b1100011) ? 2'b10 : (o == 7'b1101111) ? 2'b11 : 2'b00;
         set_instr(o, f3, f7);
         zero = z; alu_neg = ng;
         foreach (cq[k]) begin
            st = cq[k].st;
            mr = cq[k].mr;
            mem_ready = mr;
            #1;
            rs = (st == 0) ? 2'b10 : (st == 4) ? 2'b01 : 2'b00;
            sa = (st == 1 || st == 10) ? 2'b01 : (st == 2 || st == 6 || st == 7 || st == 9) ? 2'b10 : 2'b00;
            sb = (st == 0 || st == 10) ? 2'b10 : (st == 1 || st == 2 || st == 7) ? 2'b01 : 2'b00;
            expv = {4'(st),
                    (st == 0 && mr) || (st == 9 && tk) || st == 10,
                    st == 3 || st == 5,
                    st == 5,
                    st == 0 && mr,
                    st == 4 || st == 8,
                    k == cq.size() - 1,
                    cls == 6 && st == 1,
                    rs, sa, sb, exp_imm, model_alu(st, cls == 2, f3, f7)};
            obs = {state, pc_write, adr_src, mem_write, ir_write, reg_write, instr_done, illegal,
                   result_src, alu_src_a, alu_src_b, imm_src, alu_control};
            vectors++;
            if (obs !== expv) begin
               errors++;
               $display("FAIL random[%0d] cyc %0d op=%b f3=%b: got %h, expected %h", n, k, o, f3, obs, expv);
            end
            @(negedge clk);
         end
      end
      mem_ready = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      mem_ready = 1'b0;
      zero = 1'b0;
      alu_neg = 1'b0;
      set_instr(7'b0000000, 3'b000, 1'b0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      test_reset();
      test_lw();
      test_sw_stall();
      test_alu_decode();
      test_branch();
      test_illegal();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
